// File: rtl/hwpe_ctrl_seq_div.sv
// Radix-2 restoring sequential divider: NW-bit dividend by DW-bit divisor, one quotient bit per clock.
// Optional signed mode is enabled by defining HWPE_CTRL_SEQ_DIV_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for start, no valid result
// BUSY  | iterating, one quotient bit per edge
// DONE  | result held stable, new start accepted
module hwpe_ctrl_seq_div #(
    parameter int NW = 16,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [NW-1:0] num_i,
    input  logic [DW-1:0] den_i,
    input  logic          signed_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [NW-1:0] quot_o,
    output logic [DW-1:0] rem_o,
    output logic          div_zero_o
);

    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW:0]   r;
    logic [NW-1:0] q;
    logic [DW-1:0] den_r;
    logic [DW-1:0] num_lo;
    logic          neg_q;
    logic          neg_r;
    logic          dz;
    logic          ready_r;
    logic          valid_r;

    logic          sgn_num;
    logic          sgn_den;
    logic [NW-1:0] num_mag;
    logic [DW-1:0] den_mag;
    logic [DW:0]   t;
    logic [DW:0]   t_sub;
    logic          ge;
    logic          unused_r;

`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
    assign sgn_num = signed_i & num_i[NW-1];
    assign sgn_den = signed_i & den_i[DW-1];
`else
    logic unused_signed;
    assign unused_signed = signed_i;
    assign sgn_num       = 1'b0;
    assign sgn_den       = 1'b0;
`endif

    assign num_mag = sgn_num ? -num_i : num_i;
    assign den_mag = sgn_den ? -den_i : den_i;

    assign t        = {r[DW-1:0], q[NW-1]};
    assign t_sub    = t - {1'b0, den_r};
    assign ge       = (t >= {1'b0, den_r});
    assign unused_r = r[DW];

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state   <= IDLE;
            cnt     <= '0;
            r       <= '0;
            q       <= '0;
            den_r   <= '0;
            num_lo  <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state   <= BUSY;
                        cnt     <= '0;
                        r       <= '0;
                        q       <= num_mag;
                        den_r   <= den_mag;
                        num_lo  <= num_i[DW-1:0];
                        neg_q   <= sgn_num ^ sgn_den;
                        neg_r   <= sgn_num;
                        dz      <= (den_i == '0);
                        ready_r <= 1'b0;
                        valid_r <= 1'b0;
                    end
                end
                BUSY: begin
                    r   <= ge ? t_sub : t;
                    q   <= {q[NW-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NW - 1)) begin
                        state   <= DONE;
                        ready_r <= 1'b1;
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Divide-by-zero overrides the natural datapath result with the fixed pattern.
    assign ready_o    = ready_r;
    assign valid_o    = valid_r;
    assign div_zero_o = dz;
    assign quot_o     = dz ? '1 : (neg_q ? -q : q);
    assign rem_o      = dz ? num_lo : (neg_r ? -r[DW-1:0] : r[DW-1:0]);

endmodule

// File: tb/tb_hwpe_ctrl_seq_div.sv
// Scoreboard bench for hwpe_ctrl_seq_div: expected results queued at issue, popped by a monitor on valid_o rising.
module tb_hwpe_ctrl_seq_div;

    localparam int NW = 16;
    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          start_i;
    logic [NW-1:0] num_i;
    logic [DW-1:0] den_i;
    logic          signed_i;
    logic          ready_o;
    logic          valid_o;
    logic [NW-1:0] quot_o;
    logic [DW-1:0] rem_o;
    logic          div_zero_o;

    hwpe_ctrl_seq_div #(.NW(NW), .DW(DW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .num_i      (num_i),
        .den_i      (den_i),
        .signed_i   (signed_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .quot_o     (quot_o),
        .rem_o      (rem_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
        int            t;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic exp_t model(input logic [NW-1:0] n, input logic [DW-1:0] d, input logic s);
        exp_t e;
        int   sn, sd;
        e.t  = 0;
        e.dz = (d == 0);
        if (d == 0) begin
            e.q = '1;
            e.r = n[DW-1:0];
        end else if (s) begin
            sn  = int'($signed(n));
            sd  = int'($signed(d));
            e.q = NW'(sn / sd);
            e.r = DW'(sn % sd);
        end else begin
            e.q = NW'(int'(n) / int'(d));
            e.r = DW'(int'(n) % int'(d));
        end
        return e;
    endfunction

    always @(negedge clk_i) begin
        exp_t e;
        if (valid_o && !prev_valid) begin
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_valid: got valid with empty scoreboard (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("quot", int'(quot_o), int'(e.q));
                chk("rem", int'(rem_o), int'(e.r));
                chk("div_zero", int'(div_zero_o), int'(e.dz));
                chk("latency", cyc - e.t, NW + 1);
            end
        end
        prev_valid = valid_o;
    end

    task automatic wait_ready();
        int k = 0;
        while (!ready_o && k < 4 * NW) begin
            @(negedge clk_i);
            k++;
        end
        if (!ready_o) chk("ready_timeout", 0, 1);
    endtask

    // Issue one operation; pushes expectation unless 'track' is 0.
    task automatic issue(input logic [NW-1:0] n, input logic [DW-1:0] d, input logic s, input logic track);
        exp_t e;
        @(negedge clk_i);
        wait_ready();
        num_i    = n;
        den_i    = d;
        signed_i = s;
        start_i  = 1'b1;
        if (track) begin
`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
            e = model(n, d, s);
`else
            e = model(n, d, 1'b0);
`endif
            e.t = cyc;
            sb.push_back(e);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        num_i   = NW'($urandom);
        den_i   = DW'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 4 * NW) begin
            @(negedge clk_i);
            k++;
        end
        chk("drained", sb.size(), 0);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_ready"}, int'(ready_o), 1);
        chk({nm, "_valid"}, int'(valid_o), 0);
        chk({nm, "_quot"}, int'(quot_o), 0);
        chk({nm, "_rem"}, int'(rem_o), 0);
    endtask

    initial begin
        rst_ni   = 1'b0;
        clear_i  = 1'b0;
        start_i  = 1'b0;
        num_i    = '0;
        den_i    = '0;
        signed_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        check_idle("reset");
        chk("reset_dz", int'(div_zero_o), 0);

        // Basic unsigned, with busy-ready check
        issue(16'd1000, 8'd7, 1'b0, 1'b1);
        chk("busy_ready", int'(ready_o), 0);
        drain();
        issue(16'hFFFF, 8'hFF, 1'b0, 1'b1);
        drain();

        // Divide by zero, then flag cleared by next start
        issue(16'h1234, 8'h00, 1'b0, 1'b1);
        drain();
        issue(16'd9, 8'd3, 1'b0, 1'b1);
        chk("dz_cleared_on_start", int'(div_zero_o), 0);
        drain();

        // Start during BUSY must be ignored
        issue(16'd1000, 8'd7, 1'b0, 1'b1);
        repeat (2) @(negedge clk_i);
        num_i   = 16'd5;
        den_i   = 8'd1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        drain();

        // Back-to-back from DONE
        issue(16'd50, 8'd5, 1'b0, 1'b1);
        chk("b2b_valid_drop", int'(valid_o), 0);
        drain();

        // Abort with clear
        issue(16'd1000, 8'd7, 1'b0, 1'b0);
        repeat (4) @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check_idle("clear_abort");

        // Abort with reset
        issue(16'd1000, 8'd7, 1'b0, 1'b0);
        repeat (4) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check_idle("rst_abort");

        // Clear beats start in IDLE
        num_i   = 16'd77;
        den_i   = 8'd3;
        start_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        clear_i = 1'b0;
        chk("clr_start_ready", int'(ready_o), 1);
        repeat (NW + 3) @(negedge clk_i);
        chk("clr_start_no_valid", int'(valid_o), 0);

`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
        issue(16'hFF9C, 8'd7, 1'b1, 1'b1);
        drain();
        issue(16'h8000, 8'hFF, 1'b1, 1'b1);
        drain();
        issue(16'hFF9C, 8'h00, 1'b1, 1'b1);
        drain();
        for (int i = 0; i < 15; i++) begin
            issue(NW'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : DW'($urandom), 1'b1, 1'b1);
        end
        drain();
`endif

        // Randomized unsigned (and signed_i toggled, ignored unless signed build)
        for (int i = 0; i < 30; i++) begin
            issue(NW'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : DW'($urandom),
                  1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
